// File: rtl/lut_pkg.sv
// Shared constants and FSM state encoding for the lookup-table initiator.
package lut_pkg;

  localparam int LUT_ADDR_W = 4;
  localparam int LUT_DATA_W = 4;
  localparam int LUT_DEPTH  = 2**LUT_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4,
    ST_FILL     = 3'd5
  } state_e;

endpackage

// File: rtl/lut_master.sv
// Sole initiator of the lookup table: single read/write requests plus a streaming bulk fill.
// Handshakes: a beat transfers on the rising edge where valid && ready; ready never depends on valid.
module lut_master
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              fill_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              fill_done,
  output logic              busy,
  output logic [ADDR_W-1:0] lut_addrW,
  output logic              lut_we,
  output logic [DATA_W-1:0] lut_din,
  output logic [ADDR_W-1:0] lut_addrR,
  output logic              lut_re,
  input  logic [DATA_W-1:0] lut_dout,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_lut_we, w_we_nxt;
  logic              r_lut_re, w_re_nxt;
  logic [ADDR_W-1:0] r_lut_addrW, w_addrw_nxt;
  logic [DATA_W-1:0] r_lut_din, w_din_nxt;
  logic [ADDR_W-1:0] r_lut_addrR, w_addrr_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_fill_done, w_fill_done_nxt;
  logic              w_req_ready;
  logic              w_req_acc;

  // fill_start wins over a simultaneous request, so ready drops whenever it is raised.
  assign w_req_ready = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !fill_start;
  assign w_req_acc   = req_valid && w_req_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = 1'b0;
    w_re_nxt        = 1'b0;
    w_addrw_nxt     = r_lut_addrW;
    w_din_nxt       = r_lut_din;
    w_addrr_nxt     = r_lut_addrR;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_fill_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_state_nxt = ST_IDLE;
        if ((r_state == ST_IDLE) && fill_start) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
        end else if (w_req_acc) begin
          if (req_write) begin
            w_state_nxt = ST_WR;
            w_we_nxt    = 1'b1;
            w_addrw_nxt = req_addr;
            w_din_nxt   = req_data;
          end else begin
            w_state_nxt = ST_RD_ISSUE;
            w_re_nxt    = 1'b1;
            w_addrr_nxt = req_addr;
          end
        end
      end
      ST_WR:       w_state_nxt = ST_IDLE;
      ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // The table presents read data one cycle after lut_re.
        w_rsp_data_nxt  = lut_dout;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end
      ST_FILL: begin
        if (load_valid) begin
          w_we_nxt    = 1'b1;
          w_addrw_nxt = r_cnt;
          w_din_nxt   = load_data;
          w_cnt_nxt   = r_cnt + ADDR_W'(1);
          if (r_cnt == LAST_ADDR) begin
            w_cnt_nxt       = '0;
            w_fill_done_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_lut_we    <= 1'b0;
      r_lut_re    <= 1'b0;
      r_lut_addrW <= '0;
      r_lut_din   <= '0;
      r_lut_addrR <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lut_we    <= w_we_nxt;
      r_lut_re    <= w_re_nxt;
      r_lut_addrW <= w_addrw_nxt;
      r_lut_din   <= w_din_nxt;
      r_lut_addrR <= w_addrr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_fill_done <= w_fill_done_nxt;
    end
  end

  assign req_ready  = w_req_ready;
  assign load_ready = (r_state == ST_FILL);
  assign busy       = (r_state != ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign fill_done  = r_fill_done;
  assign lut_we     = r_lut_we;
  assign lut_re     = r_lut_re;
  assign lut_addrW  = r_lut_addrW;
  assign lut_din    = r_lut_din;
  assign lut_addrR  = r_lut_addrR;
  assign dbg_state  = r_state;

endmodule
